// File: rtl/regfile_pkg.sv
// Shared definitions for the NPC general-purpose register file and its dump engine.
package regfile_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks register indices 0..NREG-1 under a valid/ready handshake.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump_req,
    input  logic            dump_ready,
    output dump_state_e     state,
    output logic [AW-1:0]   idx,
    output logic            advance,
    output logic            valid,
    output logic            busy,
    output logic            last,
    output logic            done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    dump_state_e   state_r, state_nx;
    logic [AW-1:0] idx_r, idx_nx;
    logic          send_r;
    logic          last_r;
    logic          done_r;

    // Next-state and next-index decode
    always_comb begin
        state_nx = state_r;
        idx_nx   = idx_r;
        case (state_r)
            IDLE: begin
                if (dump_req) begin
                    state_nx = SEND;
                    idx_nx   = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx = idx_r + AW'(1);
                    end
                end else begin
                    state_nx = SEND;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, index and status flags, all flopped from the next-state values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            send_r  <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            idx_r   <= idx_nx;
            send_r  <= (state_nx == SEND);
            last_r  <= (state_nx == SEND) && (idx_nx == LAST_IDX);
            done_r  <= (state_nx == DONE);
        end
    end

    assign state   = state_r;
    assign idx     = idx_r;
    assign advance = (state_r == SEND) && dump_ready;
    assign valid   = send_r;
    assign busy    = send_r;
    assign last    = last_r;
    assign done    = done_r;

endmodule

// File: rtl/regfile_dump.sv
// NPC register file: NRD combinational read ports, optional write bypass,
// debug peek port and a handshaked sequential dump of every register.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREG   = NREG_DEF,
    parameter  int NRD    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    input  logic                dump_req,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_last,
    output logic                dump_busy,
    output logic                dump_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    logic [XLEN-1:0] regs_r [NREG];
    logic [XLEN-1:0] dump_data_r;
    dump_state_e     state_s;
    logic [AW-1:0]   idx_s;
    logic            advance_s;

    regfile_dump_ctrl #(.NREG(NREG)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .state      (state_s),
        .idx        (idx_s),
        .advance    (advance_s),
        .valid      (dump_valid),
        .busy       (dump_busy),
        .last       (dump_last),
        .done       (dump_done)
    );

    // Storage array; register 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Debug peek always shows the stored value
    always_comb begin
        dbg_data = '0;
        if (dbg_addr == '0) begin
            dbg_data = '0;
        end else begin
            dbg_data = regs_r[dbg_addr];
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   ra_s;
        logic [XLEN-1:0] rd_s;

        assign ra_s = raddr[gi*AW +: AW];

        // Read mux with optional same-cycle forwarding of the write port
        always_comb begin
            rd_s = '0;
            if (ra_s == '0) begin
                rd_s = '0;
            end else if ((BYPASS != 0) && wen && (waddr == ra_s)) begin
                rd_s = wdata;
            end else begin
                rd_s = regs_r[ra_s];
            end
        end

        assign rdata[gi*XLEN +: XLEN] = rd_s;
    end

    // Beat data is a snapshot taken at start or handshake, so later writes never disturb it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dump_data_r <= '0;
        end else if ((state_s == IDLE) && dump_req) begin
            dump_data_r <= '0;
        end else if (advance_s && (idx_s != LAST_IDX)) begin
            dump_data_r <= regs_r[idx_s + AW'(1)];
        end
    end

    assign dump_idx  = idx_s;
    assign dump_data = dump_data_r;

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: directed register traffic plus full dumps.
module tb_regfile_dump;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                wen = 1'b0;
    logic [AW-1:0]       waddr = '0;
    logic [XLEN-1:0]     wdata = '0;
    logic [NRD*AW-1:0]   raddr = '0;
    logic [NRD*XLEN-1:0] rdata, rdata_nb;
    logic [AW-1:0]       dbg_addr = '0;
    logic [XLEN-1:0]     dbg_data, dbg_data_nb;
    logic                dump_req = 1'b0;
    logic                dump_ready = 1'b1;
    logic                dump_valid, dump_last, dump_busy, dump_done;
    logic [AW-1:0]       dump_idx;
    logic [XLEN-1:0]     dump_data;
    logic                nb_valid, nb_last, nb_busy, nb_done;
    logic [AW-1:0]       nb_idx;
    logic [XLEN-1:0]     nb_data;

    typedef struct {
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
        logic            last;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic  mon_en   = 1'b0;
    logic  done_exp = 1'b0;

    always #5 clk = ~clk;

    regfile_dump #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    // Second instance without bypass, fed the same register traffic
    regfile_dump #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_nb), .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb),
        .dump_req(1'b0), .dump_valid(nb_valid), .dump_ready(1'b1),
        .dump_idx(nb_idx), .dump_data(nb_data), .dump_last(nb_last),
        .dump_busy(nb_busy), .dump_done(nb_done)
    );

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int mode, input int i);
        case (mode)
            1:       return (i == 4) ? 64'h99 : XLEN'(i * 16);
            2:       return 64'h0;
            3:       return (i == 3) ? 64'h77 : ((i == 4) ? 64'h99 : XLEN'(i * 16));
            default: return XLEN'(i * 16);
        endcase
    endfunction

    task automatic push_dump(input int mode);
        beat_t b;
        for (int i = 0; i < NREG; i++) begin
            b.idx  = AW'(i);
            b.data = exp_data(mode, i);
            b.last = (i == NREG - 1);
            exp_q.push_back(b);
        end
    endtask

    // Accept NREG beats; optionally stall beat stall_idx for 3 cycles and write regs 3/4 meanwhile
    task automatic drive_beats(input int stall_idx, input bit do_wr);
        for (int b = 0; b < NREG; b++) begin
            if (b == stall_idx) begin
                dump_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    if (do_wr && s == 0) begin
                        wen = 1'b1; waddr = 5'd3; wdata = 64'h77;
                    end else if (do_wr && s == 1) begin
                        wen = 1'b1; waddr = 5'd4; wdata = 64'h99;
                    end else begin
                        wen = 1'b0;
                    end
                    step();
                end
                wen = 1'b0;
                dump_ready = 1'b1;
            end
            step();
        end
    endtask

    // Monitor: compare every presented beat against the queue front; pop on handshake
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            done_exp = 1'b0;
        end else if (mon_en) begin
            chk("dump_done", {63'd0, dump_done}, {63'd0, done_exp});
            done_exp = 1'b0;
            if (dump_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dump_extra_beat actual_idx=%0d required=none", dump_idx);
                end else begin
                    chk("dump_idx", {59'd0, dump_idx}, {59'd0, exp_q[0].idx});
                    chk("dump_data", dump_data, exp_q[0].data);
                    chk("dump_last", {63'd0, dump_last}, {63'd0, exp_q[0].last});
                    chk("dump_busy", {63'd0, dump_busy}, 64'd1);
                    if (dump_ready) begin
                        done_exp = exp_q[0].last;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, dump_valid}, 64'd0);
        chk("rst_busy", {63'd0, dump_busy}, 64'd0);
        chk("rst_done", {63'd0, dump_done}, 64'd0);
        chk("rst_last", {63'd0, dump_last}, 64'd0);
        chk("rst_idx", {59'd0, dump_idx}, 64'd0);
        chk("rst_data", dump_data, 64'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        raddr = {5'd1, 5'd6};
        dbg_addr = 5'd5;
        #1;
        chk("rd0_after_rst", rdata[63:0], 64'd0);
        chk("rd1_after_rst", rdata[127:64], 64'd0);
        chk("dbg_after_rst", dbg_data, 64'd0);

        wen = 1'b1; waddr = 5'd6; wdata = 64'h1234;
        step();
        waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF; raddr = {5'd0, 5'd6};
        #1;
        chk("bypass_reg0", rdata[127:64], 64'd0);
        step();
        wen = 1'b0;
        #1;
        chk("rd_reg6", rdata[63:0], 64'h1234);
        chk("rd_reg0", rdata[127:64], 64'd0);

        wen = 1'b1; waddr = 5'd5; wdata = 64'h5555;
        step();
        wdata = 64'hABCD; raddr = {5'd0, 5'd5};
        #1;
        chk("bypass_rd", rdata[63:0], 64'hABCD);
        chk("bypass_dbg_old", dbg_data, 64'h5555);
        chk("nobypass_rd_old", rdata_nb[63:0], 64'h5555);
        step();
        wen = 1'b0;
        #1;
        chk("dbg_after_write", dbg_data, 64'hABCD);

        for (int i = 1; i < NREG; i++) begin
            wen = 1'b1; waddr = AW'(i); wdata = XLEN'(i * 16);
            step();
        end
        wen = 1'b0;
        raddr = {5'd31, 5'd16};
        #1;
        chk("rd_reg16", rdata[63:0], 64'h100);
        chk("rd_reg31", rdata[127:64], 64'h1F0);

        // Dump A: back-pressure on beat 4
        dump_req = 1'b1;
        push_dump(0);
        step();
        dump_req = 1'b0;
        drive_beats(4, 1'b0);

        // Dump B: requested during DONE, must start only from IDLE; writes while beat 3 stalls
        dump_req = 1'b1;
        push_dump(1);
        step();
        chk("b2b_idle_valid", {63'd0, dump_valid}, 64'd0);
        step();
        dump_req = 1'b0;
        drive_beats(3, 1'b1);
        step();
        chk("queue_empty_b", XLEN'(exp_q.size()), 64'd0);
        raddr = {5'd4, 5'd3};
        #1;
        chk("rd_reg3_new", rdata[63:0], 64'h77);
        chk("rd_reg4_new", rdata[127:64], 64'h99);

        // Dump C: reset while beat 10 is presented
        dump_req = 1'b1;
        push_dump(3);
        step();
        dump_req = 1'b0;
        for (int b = 0; b < 10; b++) step();
        dump_ready = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, dump_valid}, 64'd0);
        chk("midrst_busy", {63'd0, dump_busy}, 64'd0);
        chk("midrst_last", {63'd0, dump_last}, 64'd0);
        chk("midrst_idx", {59'd0, dump_idx}, 64'd0);
        chk("midrst_data", dump_data, 64'd0);
        step();
        step();
        rst = 1'b1;
        raddr = {5'd31, 5'd3};
        #1;
        chk("cleared_reg3", rdata[63:0], 64'd0);
        chk("cleared_reg31", rdata[127:64], 64'd0);

        // Dump D: fresh dump of cleared file
        dump_ready = 1'b1;
        dump_req = 1'b1;
        push_dump(2);
        step();
        dump_req = 1'b0;
        drive_beats(-1, 1'b0);
        step();
        chk("queue_empty_d", XLEN'(exp_q.size()), 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
